// File: rtl/rover_cmd_queue_fsm.sv
// Rover command sequencer: queues move commands in a FIFO and issues them one
// at a time to the move controller. It has a per-move watchdog, abort/flush and
// a halt pulse toward the drive.
//
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   cmd_valid/ready command push handshake; cmd_data is the move word
//   abort           flushes the queue, cancels the current move, clears error
//   move_done       the current move has finished (pulse or level)
//   move_data       command being executed (0 when idle)
//   start_move      one-cycle pulse while move_data is first valid
//   halt            one-cycle stop pulse (abort or timeout while moving)
//   timeout_err     sticky watchdog error
//   busy            a move is in progress or commands are queued
//   count           number of queued commands, excluding the executing one
//   state           debug state code (0 idle, 1 moving)

module rover_cmd_queue_fsm #(
    parameter int DATA_W         = 12,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       cmd_ready,
    input  logic                       abort,
    input  logic                       move_done,
    output logic [DATA_W-1:0]          move_data,
    output logic                       start_move,
    output logic                       halt,
    output logic                       timeout_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [3:0]                 state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    // A disabled watchdog still gets a 1-bit timer so the vector is legal.
    localparam int TW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    typedef enum logic [3:0] {
        IDLE   = 4'h0,
        MOVING = 4'h1
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     timer_q;
    state_e            state_q;
    logic [DATA_W-1:0] move_data_q;
    logic              start_q;
    logic              halt_q;
    logic              err_q;

    logic push;
    logic pop;
    logic expire;

    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready && !abort;
    assign pop       = (state_q == IDLE) && (count_q != '0) && !abort;
    // The watchdog fires only in a MOVING cycle without move_done, so a done
    // arriving in the last allowed cycle wins over expiry.
    assign expire    = (TIMEOUT_CYCLES != 0) && (state_q == MOVING) &&
                       !move_done && (timer_q == T_LAST);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        // Abort and timeout both flush, and that also drops a same-cycle push.
        if (abort || expire) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_q] <= cmd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            move_data_q <= '0;
            start_q     <= 1'b0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else if (abort) begin
            halt_q      <= (state_q == MOVING);
            state_q     <= IDLE;
            move_data_q <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            start_q <= 1'b0;
            halt_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        move_data_q <= mem_q[rd_q];
                        start_q     <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= MOVING;
                    end
                end
                MOVING: begin
                    if (move_done) begin
                        move_data_q <= '0;
                        state_q     <= IDLE;
                    end else if (expire) begin
                        err_q       <= 1'b1;
                        halt_q      <= 1'b1;
                        move_data_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign move_data   = move_data_q;
    assign start_move  = start_q;
    assign halt        = halt_q;
    assign timeout_err = err_q;
    assign count       = count_q;
    assign state       = state_q;
    assign busy        = (state_q == MOVING) || (count_q != '0);

endmodule
